// File: rtl/dft_mode_ctrl.sv
// dft_mode_ctrl: wraps a DFT core so that one core can compute both DFT and iDFT.
// The iDFT is obtained by conjugating the input, running the forward DFT and
// conjugating the output. A small mode FIFO carries {inv, shift} for every block
// from the input side to the output side, because several blocks may be inside
// the core at the same time.
//
// Handshake: a sample is transferred on any cycle with its *_data_val strobe high;
// a *_block_sync strobe only counts together with the matching data_val. There is
// no back-pressure in either direction.
module dft_mode_ctrl #(
   parameter int IN_W    = 16,
   parameter int OUT_W   = 16,
   parameter int DEPTH   = 4,
   parameter int SHIFT_W = 4
) (
   input  logic                       clk_sys,
   input  logic                       rst_sys,
   // upstream
   input  logic                       block_sync_i,
   input  logic                       data_val_i,
   input  logic [IN_W-1:0]            data_real_i,
   input  logic [IN_W-1:0]            data_imag_i,
   input  logic [11:0]                trans_len_i,
   input  logic                       inv_en_i,
   input  logic [SHIFT_W-1:0]         shift_i,
   // towards the core
   output logic                       core_block_sync_o,
   output logic                       core_data_val_o,
   output logic [IN_W-1:0]            core_data_real_o,
   output logic [IN_W-1:0]            core_data_imag_o,
   output logic [11:0]                core_trans_len_o,
   // from the core
   input  logic                       core_block_sync_i,
   input  logic                       core_data_val_i,
   input  logic [OUT_W-1:0]           core_data_real_i,
   input  logic [OUT_W-1:0]           core_data_imag_i,
   input  logic [11:0]                core_trans_len_i,
   input  logic [10:0]                core_data_index_i,
   // downstream
   output logic                       block_sync_o,
   output logic                       data_val_o,
   output logic [OUT_W-1:0]           data_real_o,
   output logic [OUT_W-1:0]           data_imag_o,
   output logic [11:0]                trans_len_o,
   output logic [10:0]                data_index_o,
   output logic                       inv_en_o,
   // status
   output logic                       fifo_ovf_o,
   output logic                       fifo_unf_o,
   input  logic                       clr_err_i,
   output logic [$clog2(DEPTH):0]     inflight_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int MW = 1 + SHIFT_W;

   localparam logic signed [OUT_W+1:0] OUT_MAX = {3'b000, {(OUT_W-1){1'b1}}};

   // saturating negation on the input sample width
   function automatic logic [IN_W-1:0] neg_in(input logic [IN_W-1:0] x);
      if (x == {1'b1, {(IN_W-1){1'b0}}}) return {1'b0, {(IN_W-1){1'b1}}};
      return -x;
   endfunction

   // saturating negation on the output sample width
   function automatic logic [OUT_W-1:0] neg_out(input logic [OUT_W-1:0] x);
      if (x == {1'b1, {(OUT_W-1){1'b0}}}) return {1'b0, {(OUT_W-1){1'b1}}};
      return -x;
   endfunction

   // arithmetic right shift with round-half-up; two guard bits keep the rounding
   // add from wrapping, and only the positive side can exceed the output range
   function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] x,
                                              input logic [SHIFT_W-1:0] sh);
      logic signed [OUT_W+1:0] wide;
      logic signed [OUT_W+1:0] rnd;
      wide = {{2{x[OUT_W-1]}}, x};
      rnd  = '0;
      if (sh != '0) rnd = (OUT_W+2)'(1) << (sh - SHIFT_W'(1));
      wide = (wide + rnd) >>> sh;
      if (wide > OUT_MAX) wide = OUT_MAX;
      return wide[OUT_W-1:0];
   endfunction

   // ---------------------------------------------------------------- mode FIFO
   logic [MW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] count;
   logic          full, empty;
   logic          push, pop;
   logic [MW-1:0] push_entry, pop_entry;
   logic          do_wr, do_rd, set_ovf, set_unf;

   assign push       = block_sync_i & data_val_i;
   assign pop        = core_block_sync_i & core_data_val_i;
   assign push_entry = {inv_en_i, shift_i};
   assign count      = wr_ptr - rd_ptr;
   assign full       = (count == PW'(DEPTH));
   assign empty      = (count == '0);
   assign inflight_o = count;

   // FIFO control: a push into an empty FIFO with a same-cycle pop bypasses storage
   always_comb begin
      do_wr     = 1'b0;
      do_rd     = 1'b0;
      set_ovf   = 1'b0;
      set_unf   = 1'b0;
      pop_entry = '0;
      if (pop) begin
         if (!empty) begin
            pop_entry = mem[rd_ptr[AW-1:0]];
            do_rd     = 1'b1;
            do_wr     = push;
         end else if (push) begin
            pop_entry = push_entry;
         end else begin
            set_unf   = 1'b1;
         end
      end else if (push) begin
         if (!full) do_wr   = 1'b1;
         else       set_ovf = 1'b1;
      end
   end

   // FIFO pointers; the extra MSB tells full from empty after wrap-around
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // FIFO storage, needs no reset since the pointers qualify every entry
   always_ff @(posedge clk_sys) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

   // sticky error flags, clear wins over a same-cycle set
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         fifo_ovf_o <= 1'b0;
         fifo_unf_o <= 1'b0;
      end else if (clr_err_i) begin
         fifo_ovf_o <= 1'b0;
         fifo_unf_o <= 1'b0;
      end else begin
         if (set_ovf) fifo_ovf_o <= 1'b1;
         if (set_unf) fifo_unf_o <= 1'b1;
      end
   end

   // --------------------------------------------------------------- input path
   logic            in_mode;
   logic            in_inv;
   logic [IN_W-1:0] in_imag;

   // the sync sample uses the new mode directly, later samples the latched one
   always_comb begin
      in_inv  = push ? inv_en_i : in_mode;
      in_imag = in_inv ? neg_in(data_imag_i) : data_imag_i;
   end

   // one register stage towards the core
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         in_mode           <= 1'b0;
         core_block_sync_o <= 1'b0;
         core_data_val_o   <= 1'b0;
         core_data_real_o  <= '0;
         core_data_imag_o  <= '0;
         core_trans_len_o  <= '0;
      end else begin
         if (push) in_mode <= inv_en_i;
         core_block_sync_o <= block_sync_i;
         core_data_val_o   <= data_val_i;
         core_data_real_o  <= data_real_i;
         core_data_imag_o  <= in_imag;
         core_trans_len_o  <= trans_len_i;
      end
   end

   // -------------------------------------------------------------- output path
   logic [MW-1:0]      out_mode;
   logic [MW-1:0]      out_eff;
   logic               out_inv;
   logic [OUT_W-1:0]   out_real, out_imag_sc, out_imag;

   // popped entry applies to the sync sample itself, out_mode to the rest
   always_comb begin
      out_eff     = pop ? pop_entry : out_mode;
      out_inv     = out_eff[SHIFT_W];
      out_real    = scale(core_data_real_i, out_eff[SHIFT_W-1:0]);
      out_imag_sc = scale(core_data_imag_i, out_eff[SHIFT_W-1:0]);
      out_imag    = out_inv ? neg_out(out_imag_sc) : out_imag_sc;
   end

   // one register stage downstream; sample data and mode hold between valids
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         out_mode     <= '0;
         block_sync_o <= 1'b0;
         data_val_o   <= 1'b0;
         data_real_o  <= '0;
         data_imag_o  <= '0;
         trans_len_o  <= '0;
         data_index_o <= '0;
         inv_en_o     <= 1'b0;
      end else begin
         if (pop) out_mode <= pop_entry;
         block_sync_o <= core_block_sync_i;
         data_val_o   <= core_data_val_i;
         trans_len_o  <= core_trans_len_i;
         data_index_o <= core_data_index_i;
         if (core_data_val_i) begin
            data_real_o <= out_real;
            data_imag_o <= out_imag;
            inv_en_o    <= out_inv;
         end
      end
   end

endmodule

// File: tb/tb_dft_mode_ctrl.sv
// Directed bench for dft_mode_ctrl: inputs change on the falling edge,
// registered outputs are sampled 1 time unit after the rising edge.
module tb_dft_mode_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst_sys;
   logic        block_sync_i, data_val_i;
   logic [15:0] data_real_i, data_imag_i;
   logic [11:0] trans_len_i;
   logic        inv_en_i;
   logic [3:0]  shift_i;
   logic        core_block_sync_o, core_data_val_o;
   logic [15:0] core_data_real_o, core_data_imag_o;
   logic [11:0] core_trans_len_o;
   logic        core_block_sync_i, core_data_val_i;
   logic [15:0] core_data_real_i, core_data_imag_i;
   logic [11:0] core_trans_len_i;
   logic [10:0] core_data_index_i;
   logic        block_sync_o, data_val_o;
   logic [15:0] data_real_o, data_imag_o;
   logic [11:0] trans_len_o;
   logic [10:0] data_index_o;
   logic        inv_en_o;
   logic        fifo_ovf_o, fifo_unf_o, clr_err_i;
   logic [2:0]  inflight_o;

   int checks   = 0;
   int failures = 0;

   dft_mode_ctrl #(.IN_W(16), .OUT_W(16), .DEPTH(4), .SHIFT_W(4)) dut (
      .clk_sys           (clk_sys),
      .rst_sys           (rst_sys),
      .block_sync_i      (block_sync_i),
      .data_val_i        (data_val_i),
      .data_real_i       (data_real_i),
      .data_imag_i       (data_imag_i),
      .trans_len_i       (trans_len_i),
      .inv_en_i          (inv_en_i),
      .shift_i           (shift_i),
      .core_block_sync_o (core_block_sync_o),
      .core_data_val_o   (core_data_val_o),
      .core_data_real_o  (core_data_real_o),
      .core_data_imag_o  (core_data_imag_o),
      .core_trans_len_o  (core_trans_len_o),
      .core_block_sync_i (core_block_sync_i),
      .core_data_val_i   (core_data_val_i),
      .core_data_real_i  (core_data_real_i),
      .core_data_imag_i  (core_data_imag_i),
      .core_trans_len_i  (core_trans_len_i),
      .core_data_index_i (core_data_index_i),
      .block_sync_o      (block_sync_o),
      .data_val_o        (data_val_o),
      .data_real_o       (data_real_o),
      .data_imag_o       (data_imag_o),
      .trans_len_o       (trans_len_o),
      .data_index_o      (data_index_o),
      .inv_en_o          (inv_en_o),
      .fifo_ovf_o        (fifo_ovf_o),
      .fifo_unf_o        (fifo_unf_o),
      .clr_err_i         (clr_err_i),
      .inflight_o        (inflight_o)
   );

   // clock
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   task automatic idle();
      block_sync_i      = 1'b0;
      data_val_i        = 1'b0;
      data_real_i       = '0;
      data_imag_i       = '0;
      inv_en_i          = 1'b0;
      shift_i           = '0;
      core_block_sync_i = 1'b0;
      core_data_val_i   = 1'b0;
      core_data_real_i  = '0;
      core_data_imag_i  = '0;
      core_data_index_i = '0;
      clr_err_i         = 1'b0;
   endtask

   task automatic begin_cyc();
      @(negedge clk_sys);
      idle();
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic up(input logic s, input logic inv, input logic [3:0] sh, input int re, input int im);
      block_sync_i = s;
      data_val_i   = 1'b1;
      inv_en_i     = inv;
      shift_i      = sh;
      data_real_i  = 16'(re);
      data_imag_i  = 16'(im);
   endtask

   task automatic core(input logic s, input logic v, input int re, input int im, input int idx);
      core_block_sync_i = s;
      core_data_val_i   = v;
      core_data_real_i  = 16'(re);
      core_data_imag_i  = 16'(im);
      core_data_index_i = 11'(idx);
   endtask

   initial begin
      rst_sys          = 1'b1;
      idle();
      trans_len_i      = 12'd12;
      core_trans_len_i = 12'd12;
      #2;
      check("rst_core_val", 32'(core_data_val_o), 0);
      check("rst_inflight", 32'(inflight_o), 0);
      check("rst_data_real", 32'(data_real_o), 0);
      repeat (2) @(negedge clk_sys);
      rst_sys = 1'b0;

      // pass-through
      begin_cyc(); up(1, 0, 0, 100, -50); tick();
      check("pt_core_sync", 32'(core_block_sync_o), 1);
      check("pt_core_val", 32'(core_data_val_o), 1);
      check("pt_core_real", sx(core_data_real_o), 100);
      check("pt_core_imag", sx(core_data_imag_o), -50);
      check("pt_core_tlen", 32'(core_trans_len_o), 12);
      check("pt_inflight1", 32'(inflight_o), 1);
      begin_cyc(); core(1, 1, 300, 7, 0); tick();
      check("pt_out_real", sx(data_real_o), 300);
      check("pt_out_imag", sx(data_imag_o), 7);
      check("pt_inv", 32'(inv_en_o), 0);
      check("pt_sync", 32'(block_sync_o), 1);
      check("pt_val", 32'(data_val_o), 1);
      check("pt_tlen", 32'(trans_len_o), 12);
      check("pt_inflight0", 32'(inflight_o), 0);

      // conjugation with saturation, in_mode / out_mode holding, data hold
      begin_cyc(); up(1, 1, 0, 1, -32768); tick();
      check("cj_core_real", sx(core_data_real_o), 1);
      check("cj_core_imag_sat", sx(core_data_imag_o), 32767);
      begin_cyc(); up(0, 0, 0, 2, 10); tick();
      check("cj_core_imag_inmode", sx(core_data_imag_o), -10);
      begin_cyc(); core(1, 1, 11, 5, 0); tick();
      check("cj_out_real", sx(data_real_o), 11);
      check("cj_out_imag", sx(data_imag_o), -5);
      check("cj_inv", 32'(inv_en_o), 1);
      begin_cyc(); core(0, 1, 2, 3, 1); tick();
      check("cj_outmode_imag", sx(data_imag_o), -3);
      check("cj_outmode_inv", 32'(inv_en_o), 1);
      check("cj_index", 32'(data_index_o), 1);
      begin_cyc(); core(0, 0, 999, 999, 2); tick();
      check("hold_val", 32'(data_val_o), 0);
      check("hold_real", sx(data_real_o), 2);
      check("hold_imag", sx(data_imag_o), -3);

      // shift and round
      begin_cyc(); up(1, 0, 2, 0, 0); tick();
      begin_cyc(); core(1, 1, 6, 0, 0); tick();
      check("sh_pos6", sx(data_real_o), 2);
      check("sh_inv", 32'(inv_en_o), 0);
      begin_cyc(); core(0, 1, -6, 0, 1); tick();
      check("sh_neg6", sx(data_real_o), -1);
      begin_cyc(); core(0, 1, 32767, 0, 2); tick();
      check("sh_max", sx(data_real_o), 8192);

      // three blocks queued before the first core sync
      begin_cyc(); up(1, 1, 0, 0, 0); tick();
      begin_cyc(); up(1, 0, 1, 0, 0); tick();
      begin_cyc(); up(1, 1, 2, 0, 0); tick();
      check("pl_inflight3", 32'(inflight_o), 3);
      begin_cyc(); core(1, 1, 8, 4, 0); tick();
      check("pl1_real", sx(data_real_o), 8);
      check("pl1_imag", sx(data_imag_o), -4);
      check("pl1_inv", 32'(inv_en_o), 1);
      check("pl_inflight2", 32'(inflight_o), 2);
      begin_cyc(); core(1, 1, 8, 4, 0); tick();
      check("pl2_real", sx(data_real_o), 4);
      check("pl2_imag", sx(data_imag_o), 2);
      check("pl2_inv", 32'(inv_en_o), 0);
      check("pl_inflight1", 32'(inflight_o), 1);
      begin_cyc(); core(1, 1, 8, 4, 0); tick();
      check("pl3_real", sx(data_real_o), 2);
      check("pl3_imag", sx(data_imag_o), -1);
      check("pl3_inv", 32'(inv_en_o), 1);
      check("pl_inflight0", 32'(inflight_o), 0);

      // overflow: five pushes into a four-entry FIFO
      for (int i = 0; i < 4; i++) begin
         begin_cyc(); up(1, 1, 1, 0, 0); tick();
      end
      check("ovf_inflight4", 32'(inflight_o), 4);
      check("ovf_not_yet", 32'(fifo_ovf_o), 0);
      begin_cyc(); up(1, 1, 1, 0, 0); tick();
      check("ovf_set", 32'(fifo_ovf_o), 1);
      check("ovf_inflight_stuck", 32'(inflight_o), 4);
      for (int i = 0; i < 4; i++) begin
         begin_cyc(); core(1, 1, 0, 0, 0); tick();
      end
      check("drain_inflight0", 32'(inflight_o), 0);
      check("drain_no_unf", 32'(fifo_unf_o), 0);

      // underflow: default mode {0,0}
      begin_cyc(); core(1, 1, 9, 9, 0); tick();
      check("unf_real", sx(data_real_o), 9);
      check("unf_imag", sx(data_imag_o), 9);
      check("unf_inv", 32'(inv_en_o), 0);
      check("unf_set", 32'(fifo_unf_o), 1);
      check("ovf_sticky", 32'(fifo_ovf_o), 1);

      // clear wins over a same-cycle underflow
      begin_cyc(); core(1, 1, 9, 9, 0); clr_err_i = 1'b1; tick();
      check("clr_unf", 32'(fifo_unf_o), 0);
      check("clr_ovf", 32'(fifo_ovf_o), 0);

      // bypass: push and pop together with the FIFO empty
      begin_cyc(); up(1, 1, 1, 0, 0); core(1, 1, 10, 6, 0); tick();
      check("byp_real", sx(data_real_o), 5);
      check("byp_imag", sx(data_imag_o), -3);
      check("byp_inv", 32'(inv_en_o), 1);
      check("byp_inflight", 32'(inflight_o), 0);
      check("byp_no_unf", 32'(fifo_unf_o), 0);
      check("byp_no_ovf", 32'(fifo_ovf_o), 0);

      // reset in the middle of a block
      begin_cyc(); up(1, 1, 0, 0, 0); tick();
      begin_cyc(); core(1, 1, 100, 50, 0); tick();
      begin_cyc(); up(1, 0, 0, 0, 0); tick();
      check("mid_inflight1", 32'(inflight_o), 1);
      for (int k = 1; k < 5; k++) begin
         begin_cyc(); core(0, 1, 100 + k, 50, k); tick();
      end
      check("mid_real4", sx(data_real_o), 104);
      check("mid_imag4", sx(data_imag_o), -50);
      begin_cyc(); core(0, 1, 105, 50, 5); up(0, 0, 0, 7, 7);
      #2 rst_sys = 1'b1;
      #1;
      check("mrst_real", 32'(data_real_o), 0);
      check("mrst_imag", 32'(data_imag_o), 0);
      check("mrst_inv", 32'(inv_en_o), 0);
      check("mrst_tlen", 32'(trans_len_o), 0);
      check("mrst_index", 32'(data_index_o), 0);
      check("mrst_core_tlen", 32'(core_trans_len_o), 0);
      check("mrst_inflight", 32'(inflight_o), 0);
      begin_cyc(); rst_sys = 1'b0; tick();
      begin_cyc(); up(1, 0, 1, 0, 0); tick();
      check("post_inflight1", 32'(inflight_o), 1);
      begin_cyc(); core(1, 1, 20, -20, 0); tick();
      check("post_real", sx(data_real_o), 10);
      check("post_imag", sx(data_imag_o), -10);
      check("post_inv", 32'(inv_en_o), 0);
      check("post_inflight0", 32'(inflight_o), 0);
      check("post_no_unf", 32'(fifo_unf_o), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dft_mode_ctrl.md
DFT_MODE_CTRL -- requirements
Module: dft_mode_ctrl

Interface
REQ-001 Parameters SHALL be as follows: IN_W, 16, input sample width; OUT_W, 16, output sample width; DEPTH, 4, mode-FIFO entries (power of 2, >=2); SHIFT_W, 4, per-block scaling-shift width.
REQ-002 clk_sys  in  1  single clock; all logic on the rising edge.
REQ-003 rst_sys  in  1  reset, asynchronous, active-high.
REQ-004 block_sync_i, data_val_i  in  1 each  first-sample strobe and sample-valid strobe, upstream.
REQ-005 data_real_i, data_imag_i  in  IN_W each  signed input samples.
REQ-006 trans_len_i  in  12  transform length; inv_en_i  in  1  0 = DFT, 1 = iDFT; shift_i  in  SHIFT_W  output right-shift for this block.
REQ-007 core_block_sync_o, core_data_val_o  out  1 each; core_data_real_o, core_data_imag_o  out  IN_W each; core_trans_len_o  out  12; all drive the DFT core.
REQ-008 core_block_sync_i, core_data_val_i  in  1 each; core_data_real_i, core_data_imag_i  in  OUT_W each; core_trans_len_i  in  12; core_data_index_i  in  11; all driven by the DFT core.
REQ-009 block_sync_o, data_val_o  out  1 each; data_real_o, data_imag_o  out  OUT_W each; trans_len_o  out  12; data_index_o  out  11; all downstream.
REQ-010 inv_en_o  out  1  mode of the block currently being output.
REQ-011 fifo_ovf_o, fifo_unf_o  out  1 each  sticky errors; clr_err_i  in  1  synchronous clear of both errors.
REQ-012 inflight_o  out  clog2(DEPTH)+1  number of mode entries queued.

Function
REQ-013 Input path: the block SHALL register all core_* outputs with exactly 1 cycle latency.
REQ-014 Input path: on block_sync_i & data_val_i, the block SHALL latch inv_en_i into in_mode, and that sample SHALL use inv_en_i directly.
REQ-015 Input path: later samples SHALL use in_mode; when in_mode = 1 the imaginary part SHALL be negated.
REQ-016 Negation SHALL saturate: -(-2^(W-1)) yields 2^(W-1)-1; the real part SHALL pass unchanged.
REQ-017 Mode FIFO push: {inv_en_i, shift_i} SHALL be pushed on block_sync_i & data_val_i.
REQ-018 Mode FIFO pop: an entry SHALL be popped on core_block_sync_i & core_data_val_i.
REQ-019 Mode FIFO, simultaneous push and pop: both SHALL occur, and inflight_o SHALL stay unchanged; when the FIFO was empty, the popped entry SHALL be the pushed entry (bypass).
REQ-020 Mode FIFO, push when full without a simultaneous pop: the push SHALL be dropped and fifo_ovf_o set.
REQ-021 Mode FIFO, pop when empty without bypass: the mode SHALL default to {0,0} and fifo_unf_o SHALL be set.
REQ-022 Output path: the popped entry SHALL apply to the sync sample in the same cycle and SHALL then be held in out_mode for the remainder of the block.
REQ-023 Output processing SHALL be, in order: arithmetic right shift by shift with round-half-up (add 2^(shift-1) before shifting when shift > 0), then saturating conjugation when inv = 1.
REQ-024 Rounding overflow SHALL saturate to 2^(OUT_W-1)-1.
REQ-025 Output path: all downstream outputs SHALL be registered with 1 cycle latency from core_*_i.
REQ-026 Output path: trans_len_o and data_index_o SHALL be delayed copies of their core inputs; inv_en_o SHALL be registered alongside data.
REQ-027 data_*_o SHALL be held (not zeroed) while data_val_o = 0.
REQ-028 Errors: fifo_ovf_o and fifo_unf_o SHALL stay set until clr_err_i = 1.
REQ-029 Errors: clr_err_i SHALL have priority over a same-cycle error set.
REQ-030 Wrap-around: FIFO pointers SHALL wrap modulo DEPTH, with full/empty determined by an extra pointer bit.

Reset
REQ-031 On rst_sys = 1, all outputs, in_mode, out_mode, FIFO pointers and error flags SHALL go to 0 immediately (asynchronous), including mid-block.
REQ-032 Samples in flight in the core at reset SHALL emerge with the default mode {0,0} and SHALL set fifo_unf_o.
REQ-033 Release of rst_sys SHALL take effect at the next clock edge.

Verification
REQ-034 Pass-through: inv=0, shift=0, trans_len=12, in (100,-50) -> core in (100,-50) 1 cycle later; core out (300,7) -> out (300,7) 1 cycle later; inv_en_o = 0.
REQ-035 Conjugation and saturation: inv=1, IN_W=16, imag -32768 -> core imag 32767; core out imag 5 -> data_imag_o -5, inv_en_o = 1.
REQ-036 Shift and round: shift=2, core real 6 -> out 2; core real -6 -> out -1; core real 32767 -> out 8192.
REQ-037 Pipelining: 3 blocks pushed with modes inv=1/0/1 and shifts 0/1/2 before the first core sync -> outputs take the modes in order; inflight_o goes 3,2,1,0.
REQ-038 Boundaries: DEPTH=4 with 5 pushes and no pop -> fifo_ovf_o = 1 and inflight_o = 4; core sync with FIFO empty -> mode {0,0} and fifo_unf_o = 1; push and pop in the same cycle with FIFO empty -> bypass mode applied and no error; clr_err_i -> both flags 0.
REQ-039 Reset mid-block: assert rst_sys during sample 5 of 12 -> all outputs 0 immediately; after release, a new block processes correctly with inflight_o starting at 0.
